bus_scatter: RTL and testbench
==============================

Name: bus_scatter

Overview:
- Inverse of the tree reduction over a lane bus: accepts one WIDTH-bit word per valid/ready handshake and delivers it to a chosen subset of NLANES destination lanes.
- Each lane has its own valid/ready handshake.
- Used wherever one producer (e.g. a writeback or forwarding source) feeds several consumers that may each stall independently.
- Output lane packing matches the reduction input packing: lane j, bit i sits at out_data[j*WIDTH+i].

Parameters:
- WIDTH, 4, bits per word/lane.
- NLANES, 4, number of destination lanes.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_valid  input  1  upstream word valid.
- in_ready  output  1  upstream may transfer this cycle.
- in_data  input  WIDTH  word to distribute.
- in_mask  input  NLANES  bit j set = deliver to lane j.
- out_valid  output  NLANES  per-lane valid.
- out_ready  input  NLANES  per-lane ready.
- out_data  output  WIDTH*NLANES  held word replicated into every lane slot.
- busy  output  1  a word is held with at least one lane still pending.
- done  output  1  one-cycle pulse when the final pending lane of a word is accepted.

Behaviour:
- State:
  - data_r[WIDTH]: held word.
  - pend_r[NLANES]: lanes not yet delivered.
  - done_r: registered done pulse.
- Reset (reset==0, async):
  - pend_r=0, data_r=0, done_r=0.
  - Hence out_valid=0, busy=0, done=0, out_data=0, in_ready=1.
- Outputs:
  - out_valid = pend_r.
  - busy = |pend_r.
  - out_data = data_r replicated NLANES times.
  - done = done_r.
- Lane transfer: lane j transfers when pend_r[j] && out_ready[j]. pend_clr = pend_r & out_ready. pend_after = pend_r & ~out_ready.
- in_ready = (pend_after == 0), i.e. accept when idle or when every remaining lane completes this cycle.
  - Combinational dependence on out_ready is permitted.
  - There is no dependence on in_valid.
- Accept: in_valid && in_ready.
  - in_mask != 0: data_r <= in_data; pend_r <= in_mask.
  - in_mask == 0: word consumed and discarded; data_r unchanged; pend_r <= 0; no done pulse.
- No accept: pend_r <= pend_after; data_r holds.
- Latency: a word accepted in cycle N shows out_valid in cycle N+1. Minimum lane occupancy is 1 cycle.
- Throughput: one word per cycle when all addressed lanes are ready, because of back-to-back acceptance in the final-delivery cycle.
- done_r <= (pend_r != 0) && (pend_after == 0). This fires whether or not a new word is accepted in the same cycle.
- Lanes are independent: a lane that already took the word drops out_valid even while others stall. No lane receives a word twice.
- out_data stays stable while any out_valid is high, because data_r only changes on accept, which requires pend_after==0.
- out_ready on a lane with pend_r[j]==0 is ignored.
- Reset mid-operation: pending deliveries are abandoned immediately (async). No done pulse.
- in_valid may drop without a transfer. in_data and in_mask are don't-care while in_valid==0.

Decomposition:
- Shared package or header holds:
  - Default WIDTH and NLANES constants.
  - A lane-slice index function/macro (j*WIDTH+i), so this block and the tree-reduction block agree on packing.
- One natural sub-module, scatter_lane, instantiated NLANES times in a generate loop. It contains:
  - The pend_r[j] flop with async active-low reset.
  - Load on accept, clear on out_ready.
  - Outputs out_valid[j] and pend_after[j].
- Top level holds data_r, in_ready, done_r and the replication.

Test Plan:
- Reset: drive reset=0 for 3 cycles with in_valid=1 -> out_valid=0000, busy=0, done=0, out_data=0, in_ready=1 throughout.
- Broadcast:
  - Stimulus: in_data=4'hA, in_mask=1111, all out_ready=1.
  - Next cycle: out_valid=1111 and out_data=16'hAAAA.
  - Following cycle: out_valid=0000, done pulses for exactly 1 cycle.
- Staggered stall:
  - Stimulus: in_data=4'h5, mask=0110. Lane1 ready immediately; lane2 ready after 3 cycles; a second word (4'h3, mask 1000) held valid meanwhile.
  - Lane1 valid 1 cycle; lane2 valid 4 cycles; in_ready=0 until lane2's transfer cycle.
  - Second word is accepted in that same cycle; out_data stays 16'h5555 until then.
- Back-to-back streaming:
  - Stimulus: 8 words 0..7, mask=0001, out_ready[0]=1 constantly.
  - in_ready=1 every cycle; lane0 receives 0..7 in order on consecutive cycles; done pulses 8 times.
- Zero mask: word 4'hF with mask=0000 while idle -> accepted (in_ready=1); out_valid stays 0000; data_r unchanged; no done.
- Reset mid-operation: mask=1111 with lanes stalled, assert reset for 1 cycle -> out_valid=0000 immediately (before the next edge); no done; in_ready=1 after release.

Source files
------------

// File: rtl/bus_scatter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_scatter_pkg
// Description : Shared constants and the lane-slice packing helper. Both the
//               scatter block and the tree-reduction block use this helper,
//               so they agree on how lanes are packed into the bus.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_scatter_pkg;

    localparam int c_DEF_WIDTH  = 4;
    localparam int c_DEF_NLANES = 4;

    // Flat bus bit index of bit i within lane j (lane j, bit i -> j*WIDTH+i)
    function automatic int lane_bit(input int j, input int i, input int width);
        return j * width + i;
    endfunction

endpackage : bus_scatter_pkg
`default_nettype wire

// File: rtl/bus_scatter_lane.sv
`default_nettype none
// ============================================================================
// Module      : bus_scatter_lane
// Description : One destination lane of the scatter block. Holds the lane's
//               pending flag. The flag loads from the mask bit when a word is
//               accepted and clears once the lane's consumer takes the word.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_scatter_lane (
    input  logic clk,
    input  logic reset,          // asynchronous, active-low
    input  logic i_load,         // upstream word accepted this cycle
    input  logic i_mask,         // this lane is addressed by the incoming word
    input  logic i_ready,        // consumer ready
    output logic o_valid,        // lane holds an undelivered word
    output logic o_pend_after    // lane still pending after this cycle
);

    logic r_pend;

    // A ready consumer on an idle lane changes nothing, because r_pend gates it
    assign o_valid      = r_pend;
    assign o_pend_after = r_pend & ~i_ready;

    // Pending flag: load on accept, otherwise drop once the consumer takes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 1'b0;
        end else if (i_load) begin
            r_pend <= i_mask;
        end else begin
            r_pend <= o_pend_after;
        end
    end

endmodule : bus_scatter_lane
`default_nettype wire

// File: rtl/bus_scatter.sv
`default_nettype none
// ============================================================================
// Module      : bus_scatter
// Description : Delivers one upstream word to a masked subset of lanes. Each
//               lane has an independent valid/ready handshake. A new word is
//               accepted in the same cycle that the last pending lane
//               completes, which gives full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_scatter
    import bus_scatter_pkg::*;
#(
    parameter int WIDTH  = c_DEF_WIDTH,
    parameter int NLANES = c_DEF_NLANES
) (
    input  logic                      clk,
    input  logic                      reset,      // asynchronous, active-low
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [NLANES-1:0]         in_mask,
    output logic [NLANES-1:0]         out_valid,
    input  logic [NLANES-1:0]         out_ready,
    output logic [WIDTH*NLANES-1:0]   out_data,
    output logic                      busy,
    output logic                      done
);

    logic [WIDTH-1:0]  r_data;
    logic              r_done;
    logic [NLANES-1:0] w_pend_after;
    logic              w_accept;

    // Accept is allowed once no lane will still be pending after this edge
    assign in_ready = ~|w_pend_after;
    assign w_accept = in_valid & in_ready;
    assign busy     = |out_valid;
    assign done     = r_done;

    generate
        for (genvar j = 0; j < NLANES; j++) begin : g_lane
            bus_scatter_lane u_lane (
                .clk          (clk),
                .reset        (reset),
                .i_load       (w_accept),
                .i_mask       (in_mask[j]),
                .i_ready      (out_ready[j]),
                .o_valid      (out_valid[j]),
                .o_pend_after (w_pend_after[j])
            );

            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                assign out_data[lane_bit(j, i, WIDTH)] = r_data[i];
            end
        end
    endgenerate

    // Held word: only a non-empty mask replaces it; an empty mask discards the word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (w_accept && (|in_mask)) begin
            r_data <= in_data;
        end
    end

    // Completion pulse: the last outstanding lane was taken this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (|out_valid) & ~(|w_pend_after);
        end
    end

endmodule : bus_scatter
`default_nettype wire

// File: tb/tb_bus_scatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_scatter
// Description : Self-checking bench for bus_scatter. It uses a table of
//               directed vectors, hand-written streaming and mid-operation
//               reset sequences, and randomized traffic checked against a
//               per-lane delivery model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_scatter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic [3:0]  in_mask;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    bus_scatter #(.WIDTH(4), .NLANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vector: inputs for one cycle, plus the outputs seen in that cycle
    typedef struct {
        bit          rst_n;
        bit          iv;
        logic [3:0]  d;
        logic [3:0]  m;
        logic [3:0]  rdy;
        bit          e_ir;
        logic [3:0]  e_ov;
        bit          e_busy;
        bit          e_done;
        logic [15:0] e_od;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the word being delivered and which lanes still owe it
    logic [3:0] m_word;
    bit         m_owed [4];
    bit         m_done;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_word = '0;
        m_done = 0;
        for (int j = 0; j < 4; j++) m_owed[j] = 0;
    endtask

    // Drive one cycle at the falling edge and sample 1ns later. If use_model
    // is set, compare against the model. The model then advances across the
    // next rising edge.
    task automatic cycle(input bit rs, input bit iv, input logic [3:0] d,
                         input logic [3:0] m, input logic [3:0] rdy, input bit use_model);
        logic [3:0]  e_ov;
        logic [15:0] e_od;
        bit          e_ir;
        bit          any_owed;
        bit          any_left;
        @(negedge clk);
        reset     = rs;
        in_valid  = iv;
        in_data   = d;
        in_mask   = m;
        out_ready = rdy;
        if (!rs) model_reset();
        #1;
        e_ir = 1; any_owed = 0; any_left = 0;
        for (int j = 0; j < 4; j++) begin
            e_ov[j] = m_owed[j];
            if (m_owed[j]) any_owed = 1;
            if (m_owed[j] && !rdy[j]) begin
                e_ir = 0;
                any_left = 1;
            end
        end
        e_od = {4{m_word}};
        if (use_model) begin
            chk("model_in_ready",  {15'd0, in_ready}, {15'd0, e_ir});
            chk("model_out_valid", {12'd0, out_valid}, {12'd0, e_ov});
            chk("model_busy",      {15'd0, busy},     {15'd0, any_owed});
            chk("model_done",      {15'd0, done},     {15'd0, m_done});
            chk("model_out_data",  out_data,          e_od);
        end
        if (rs) begin
            m_done = any_owed && !any_left;
            if (iv && e_ir) begin
                if (m != 0) m_word = d;
                for (int j = 0; j < 4; j++) m_owed[j] = m[j];
            end else begin
                for (int j = 0; j < 4; j++) if (rdy[j]) m_owed[j] = 0;
            end
        end
    endtask

    initial begin
        int ndone;
        reset = 1'b0; in_valid = 0; in_data = 0; in_mask = 0; out_ready = 0;
        model_reset();

        // --- directed table: reset, broadcast, staggered stall, zero mask ---
        //               rst iv d     m      rdy     ir ov     bsy dn od
        tbl.push_back('{0, 1, 4'hA, 4'hF, 4'hF,   1, 4'h0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 4'hA, 4'hF, 4'hF,   1, 4'h0, 0, 0, 16'h0000});
        tbl.push_back('{0, 1, 4'hA, 4'hF, 4'hF,   1, 4'h0, 0, 0, 16'h0000});
        tbl.push_back('{1, 1, 4'hA, 4'hF, 4'hF,   1, 4'h0, 0, 0, 16'h0000});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'hF,   1, 4'hF, 1, 0, 16'hAAAA});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'hF,   1, 4'h0, 0, 1, 16'hAAAA});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'hF,   1, 4'h0, 0, 0, 16'hAAAA});
        tbl.push_back('{1, 1, 4'h5, 4'h6, 4'h0,   1, 4'h0, 0, 0, 16'hAAAA});
        tbl.push_back('{1, 1, 4'h3, 4'h8, 4'h2,   0, 4'h6, 1, 0, 16'h5555});
        tbl.push_back('{1, 1, 4'h3, 4'h8, 4'h0,   0, 4'h4, 1, 0, 16'h5555});
        tbl.push_back('{1, 1, 4'h3, 4'h8, 4'h0,   0, 4'h4, 1, 0, 16'h5555});
        tbl.push_back('{1, 1, 4'h3, 4'h8, 4'h4,   1, 4'h4, 1, 0, 16'h5555});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'h0,   0, 4'h8, 1, 1, 16'h3333});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'h8,   1, 4'h8, 1, 0, 16'h3333});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'h0,   1, 4'h0, 0, 1, 16'h3333});
        tbl.push_back('{1, 1, 4'hF, 4'h0, 4'h0,   1, 4'h0, 0, 0, 16'h3333});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'hF,   1, 4'h0, 0, 0, 16'h3333});
        tbl.push_back('{1, 0, 4'h0, 4'h0, 4'hF,   1, 4'h0, 0, 0, 16'h3333});

        foreach (tbl[k]) begin
            cycle(tbl[k].rst_n, tbl[k].iv, tbl[k].d, tbl[k].m, tbl[k].rdy, 1'b0);
            chk($sformatf("tbl%0d_in_ready", k),  {15'd0, in_ready}, {15'd0, tbl[k].e_ir});
            chk($sformatf("tbl%0d_out_valid", k), {12'd0, out_valid}, {12'd0, tbl[k].e_ov});
            chk($sformatf("tbl%0d_busy", k),      {15'd0, busy},     {15'd0, tbl[k].e_busy});
            chk($sformatf("tbl%0d_done", k),      {15'd0, done},     {15'd0, tbl[k].e_done});
            chk($sformatf("tbl%0d_out_data", k),  out_data,          tbl[k].e_od);
        end

        // --- back-to-back streaming of words 0..7 on lane 0 ---
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) cycle(1, 1, k[3:0], 4'h1, 4'h1, 1'b1);
            else       cycle(1, 0, 4'h0,   4'h0, 4'h1, 1'b1);
            if (k < 8) chk($sformatf("stream%0d_in_ready", k), {15'd0, in_ready}, 16'd1);
            if (k >= 1 && k <= 8) begin
                chk($sformatf("stream%0d_lane0_valid", k), {12'd0, out_valid}, 16'h0001);
                chk($sformatf("stream%0d_lane0_data", k), {12'd0, out_data[3:0]}, 16'(k - 1));
            end
            if (done) ndone++;
        end
        cycle(1, 0, 4'h0, 4'h0, 4'h0, 1'b1);
        if (done) ndone++;
        chk("stream_done_count", 16'(ndone), 16'd8);

        // --- reset in the middle of a stalled broadcast ---
        cycle(1, 1, 4'h9, 4'hF, 4'h0, 1'b1);
        cycle(1, 0, 4'h0, 4'h0, 4'h0, 1'b1);
        chk("midrst_stalled_valid", {12'd0, out_valid}, 16'h000F);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid_immediate", {12'd0, out_valid}, 16'h0000);
        chk("midrst_busy_immediate",  {15'd0, busy},     16'd0);
        chk("midrst_data_immediate",  out_data,          16'h0000);
        cycle(1, 0, 4'h0, 4'h0, 4'hF, 1'b1);
        chk("midrst_done_after", {15'd0, done},     16'd0);
        chk("midrst_ready_after", {15'd0, in_ready}, 16'd1);

        // --- randomized traffic against the model ---
        for (int k = 0; k < 400; k++) begin
            logic [3:0] rm;
            logic [3:0] rr;
            rm = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            rr = 4'($urandom) & 4'($urandom | ($urandom_range(0, 1) ? 32'hF : 32'h0));
            cycle(1, ($urandom_range(0, 3) != 0), 4'($urandom), rm, rr, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_bus_scatter
`default_nettype wire
